laser_enable_sequencer: RTL

//  Sequences laser power and the TA shutdown interlock. Controls power-up with a pwr_good settle check and a

---
 rtl/laser_enable_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/laser_enable_sequencer.sv
// rtl/laser_enable_sequencer.sv - laser power / TA shutdown enable sequencer with fault latching
//
// Purpose:
//    Brings the laser supply up in stages. It waits in PWR_WAIT until pwr_good
//    has been stable for the settle time, and faults if that takes too long.
//    In RUN a host watchdog must keep being kicked. Limit-check faults,
//    power loss and watchdog expiry are latched as sticky bits. These bits are
//    cleared only when the host has dropped enable_req and pulses clear_fail.
//
// Ports:
//    clk                in   clk_div2 domain clock
//    rst                in   synchronous active-high reset
//    enable_req         in   host laser enable (level)
//    enable_error_check in   0 = fault_in ignored
//    laser_ready        in   post-reset laser settle complete
//    pwr_good           in   laser supply good (already synchronised)
//    wdog_kick          in   one-cycle host keepalive
//    fault_in[2:0]      in   {rate_lower, pulse_upper, pulse_lower} limit fails (level)
//    clear_fail         in   one-cycle fault clear request
//    laser_pwr_en       out  laser supply enable, active-high
//    ta_shutdown        out  TA shutdown, 1 = shut down
//    fault_latched[5:0] out  sticky {pwr_timeout, pwr_lost, wdog, rate, pulse_upper, pulse_lower}
//    seq_state[1:0]     out  0 IDLE, 1 PWR_WAIT, 2 RUN, 3 FAULT

module laser_enable_sequencer #(
   parameter int PWR_SETTLE_CYCLES  = 25000,
   parameter int PWR_TIMEOUT_CYCLES = 250000,
   parameter int WDOG_CYCLES        = 2500000,
   parameter int CNT_W              = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable_req,
   input  logic       enable_error_check,
   input  logic       laser_ready,
   input  logic       pwr_good,
   input  logic       wdog_kick,
   input  logic [2:0] fault_in,
   input  logic       clear_fail,
   output logic       laser_pwr_en,
   output logic       ta_shutdown,
   output logic [5:0] fault_latched,
   output logic [1:0] seq_state
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PWR_WAIT = 2'd1,
      S_RUN      = 2'd2,
      S_FAULT    = 2'd3
   } state_t;

   // Terminal (saturation) values; every counter stops here rather than wrapping.
   localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(PWR_SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_TERM    = CNT_W'(PWR_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] WDOG_TERM   = CNT_W'(WDOG_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] settle_q, settle_d;
   logic [CNT_W-1:0] tmo_q, tmo_d;
   logic [CNT_W-1:0] wdog_q, wdog_d;
   logic [5:0]       fault_q, fault_d;
   logic             en_q, en_d;
   logic             shut_q, shut_d;

   logic             flt;
   logic             wdog_expire;

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      tmo_d    = tmo_q;
      wdog_d   = wdog_q;
      fault_d  = fault_q;

      flt         = enable_error_check & (|fault_in);
      // A kick arriving in the terminal cycle rescues the watchdog.
      wdog_expire = (wdog_q == WDOG_TERM) & ~wdog_kick;

      case (state_q)
         S_IDLE: begin
            settle_d = '0;
            tmo_d    = '0;
            wdog_d   = '0;
            if (enable_req & laser_ready) begin
               state_d = S_PWR_WAIT;
            end
         end

         S_PWR_WAIT: begin
            tmo_d    = (tmo_q == TMO_TERM) ? tmo_q : tmo_q + CNT_ONE;
            settle_d = ~pwr_good ? '0 :
                       (settle_q == SETTLE_TERM) ? settle_q : settle_q + CNT_ONE;
            wdog_d   = '0;
            if (flt) begin
               state_d      = S_FAULT;
               fault_d[2:0] = fault_q[2:0] | fault_in;
            end else if (~enable_req) begin
               state_d = S_IDLE;
            end else if (tmo_q == TMO_TERM) begin
               state_d    = S_FAULT;
               fault_d[5] = 1'b1;
            end else if (pwr_good & (settle_q == SETTLE_TERM)) begin
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            wdog_d = wdog_kick ? '0 :
                     (wdog_q == WDOG_TERM) ? wdog_q : wdog_q + CNT_ONE;
            // All fault causes seen in the same cycle are recorded together.
            if (flt | ~pwr_good | wdog_expire) begin
               state_d = S_FAULT;
               if (flt) begin
                  fault_d[2:0] = fault_q[2:0] | fault_in;
               end
               if (~pwr_good) begin
                  fault_d[4] = 1'b1;
               end
               if (wdog_expire) begin
                  fault_d[3] = 1'b1;
               end
            end else if (~enable_req) begin
               state_d = S_IDLE;
            end
         end

         S_FAULT: begin
            if (flt) begin
               fault_d[2:0] = fault_q[2:0] | fault_in;
            end
            // Re-arming requires the host to have dropped enable and the limits to be clean.
            if (clear_fail & ~enable_req & ~flt) begin
               state_d = S_IDLE;
               fault_d = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they change on the same edge as the state.
      en_d   = (state_d == S_PWR_WAIT) | (state_d == S_RUN);
      shut_d = (state_d != S_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         settle_q <= '0;
         tmo_q    <= '0;
         wdog_q   <= '0;
         fault_q  <= '0;
         en_q     <= 1'b0;
         shut_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         tmo_q    <= tmo_d;
         wdog_q   <= wdog_d;
         fault_q  <= fault_d;
         en_q     <= en_d;
         shut_q   <= shut_d;
      end
   end

   assign laser_pwr_en  = en_q;
   assign ta_shutdown   = shut_q;
   assign fault_latched = fault_q;
   assign seq_state     = state_q;

endmodule
